// File: rtl/uart_arb_pkg.sv
// Shared state encoding, default sizing and width helpers for the UART TX packet arbiter.
// Pure declarations: no logic, no latency, no flow control of its own.
package uart_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_t;

    localparam int NREQ_DEF    = 4;
    localparam int DBIT_DEF    = 8;
    localparam int TIMEOUT_DEF = 255;

    // Requester index width; never below one bit so a 1-entry index stays legal.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Idle counter width; wide enough to hold TIMEOUT itself so it never wraps before compare.
    function automatic int cnt_w(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/rr_priority.sv
// Combinational round-robin pick: first set bit of req_i scanning last_i+1 .. last_i+N, mod N.
// Zero latency; no flow control, any_o qualifies idx_o.
module rr_priority #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_i,
    output logic          any_o,
    output logic [IW-1:0] idx_o
);

    localparam int SW = IW + 1;
    localparam logic [SW-1:0] NS = SW'(N);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [SW-1:0]  base;
    logic [SW-1:0]  off;
    logic [SW-1:0]  sum;

    always_comb begin
        dbl  = {req_i, req_i};
        base = {1'b0, last_i} + SW'(1);
        // Bit 0 of rot is the requester just after the previous owner.
        rot  = N'(dbl >> base);
        off  = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                off = SW'(k);
            end
        end
        sum   = base + off;
        idx_o = (sum >= NS) ? IW'(sum - NS) : sum[IW-1:0];
    end

    assign any_o = |req_i;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one UART TX FIFO write port; grant 1 cycle after request, bytes pass through combinationally.
// tx_full stalls the owner (ready low, no write); an owner silent for TIMEOUT cycles mid-packet loses the grant with an abort pulse.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NREQ    = NREQ_DEF,
    parameter int DBIT    = DBIT_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*DBIT-1:0]     req_data,
    input  logic [NREQ-1:0]          req_last,
    output logic [NREQ-1:0]          req_ready,
    input  logic                     tx_full,
    output logic                     wr_uart,
    output logic [DBIT-1:0]          w_data,
    output logic [$clog2(NREQ)-1:0]  grant_id,
    output logic                     busy,
    output logic                     abort
);

    localparam int IW = idx_w(NREQ);
    localparam int CW = cnt_w(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [IW-1:0] LAST_RST = IW'(NREQ - 1);

    arb_state_t     state_q, state_d;
    logic [IW-1:0]  grant_q, grant_d;
    logic [IW-1:0]  last_q,  last_d;
    logic [CW-1:0]  cnt_q,   cnt_d;

    logic           pick_any;
    logic [IW-1:0]  pick_idx;
    logic           own_vld;
    logic           own_last;
    logic           xfer;

    rr_priority #(
        .N  (NREQ),
        .IW (IW)
    ) u_rr (
        .req_i  (req_valid),
        .last_i (last_q),
        .any_o  (pick_any),
        .idx_o  (pick_idx)
    );

    assign own_vld  = req_valid[grant_q];
    assign own_last = req_last[grant_q];
    assign xfer     = (state_q == XFER) & own_vld & ~tx_full;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= LAST_RST;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        req_ready = '0;
        wr_uart   = 1'b0;
        abort     = 1'b0;
        w_data    = req_data[grant_q*DBIT +: DBIT];

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (pick_any) begin
                    grant_d = pick_idx;
                    state_d = XFER;
                end
            end
            XFER: begin
                req_ready[grant_q] = ~tx_full;
                wr_uart            = xfer;
                if (xfer) begin
                    cnt_d = '0;
                    if (own_last) begin
                        last_d  = grant_q;
                        state_d = IDLE;
                    end
                end else if (!own_vld) begin
                    // Only a silent owner ages the grant; FIFO backpressure never does.
                    if (cnt_q == CNT_LAST) begin
                        abort   = 1'b1;
                        last_d  = grant_q;
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy     = (state_q == XFER);
    assign grant_id = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: cycle model of the arbitration protocol plus per-source byte queues.
module tb_uart_tx_arbiter;

    localparam int NREQ = 4;
    localparam int DBIT = 8;
    localparam int TO   = 8;
    localparam int IW   = 2;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [NREQ-1:0]         req_valid;
    logic [NREQ*DBIT-1:0]    req_data;
    logic [NREQ-1:0]         req_last;
    logic [NREQ-1:0]         req_ready;
    logic                    tx_full;
    logic                    wr_uart;
    logic [DBIT-1:0]         w_data;
    logic [IW-1:0]           grant_id;
    logic                    busy;
    logic                    abort;

    uart_tx_arbiter #(
        .NREQ    (NREQ),
        .DBIT    (DBIT),
        .TIMEOUT (TO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_full   (tx_full),
        .wr_uart   (wr_uart),
        .w_data    (w_data),
        .grant_id  (grant_id),
        .busy      (busy),
        .abort     (abort)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic            last;
        logic [DBIT-1:0] dat;
    } byte_t;

    byte_t src_q[NREQ][$];
    byte_t exp_q[NREQ][$];
    int    gap[NREQ];
    int    waitc[NREQ];

    int vecs = 0;
    int errs = 0;
    int cyc  = 0;

    logic rst_cmd, full_cmd;
    bit   rnd;

    logic m_busy;
    int   m_owner, m_last, m_cnt;

    int   n_abort, abort_cyc, max_wait;
    int   wr_cycs[$];
    int   gq[$];
    logic prev_busy;
    logic [NREQ-1:0] prev_valid;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        vecs++;
        if (got !== want) begin
            errs++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    task automatic push_byte(input int s, input logic [DBIT-1:0] d, input logic l);
        byte_t b;
        b = {l, d};
        src_q[s].push_back(b);
        exp_q[s].push_back(b);
    endtask

    function automatic bit pending();
        for (int i = 0; i < NREQ; i++) begin
            if (src_q[i].size() > 0) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic flush();
        for (int i = 0; i < NREQ; i++) begin
            src_q[i].delete();
            exp_q[i].delete();
            gap[i] = 0;
        end
    endtask

    // One clock: drive after the edge, check at the falling edge, then advance model and sources.
    task automatic cycle();
        logic            exp_wr, exp_abort;
        logic [NREQ-1:0] exp_rdy;
        int              pick;
        byte_t           b, e;
        @(posedge clk);
        #1;
        cyc++;
        reset   = rst_cmd;
        tx_full = full_cmd;
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]              = (src_q[i].size() > 0) && (gap[i] == 0);
            req_data[i*DBIT +: DBIT]  = (src_q[i].size() > 0) ? src_q[i][0].dat : '0;
            req_last[i]               = (src_q[i].size() > 0) ? src_q[i][0].last : 1'b0;
        end
        @(negedge clk);
        exp_rdy   = '0;
        exp_wr    = 1'b0;
        exp_abort = 1'b0;
        if (m_busy) begin
            exp_rdy[m_owner] = ~tx_full;
            exp_wr           = req_valid[m_owner] & ~tx_full;
            exp_abort        = !req_valid[m_owner] && (m_cnt == TO - 1);
        end
        chk("wr_uart", wr_uart, exp_wr);
        chk("req_ready", req_ready, exp_rdy);
        chk("busy", busy, m_busy);
        chk("abort", abort, exp_abort);
        chk("grant_id", grant_id, m_owner);
        if (wr_uart === 1'b1) begin
            wr_cycs.push_back(cyc);
            chk("sb_avail", exp_q[m_owner].size() > 0, 1);
            if (exp_q[m_owner].size() > 0) begin
                e = exp_q[m_owner].pop_front();
                chk("w_data", w_data, e.dat);
            end
        end
        if (abort === 1'b1) begin
            n_abort++;
            abort_cyc = cyc;
        end
        if (busy === 1'b1 && prev_busy !== 1'b1) begin
            gq.push_back(int'(grant_id));
            for (int i = 0; i < NREQ; i++) begin
                if (i == int'(grant_id)) waitc[i] = 0;
                else if (prev_valid[i]) begin
                    waitc[i]++;
                    if (waitc[i] > max_wait) max_wait = waitc[i];
                end else waitc[i] = 0;
            end
        end
        prev_busy  = busy;
        prev_valid = req_valid;

        for (int i = 0; i < NREQ; i++) begin
            if (gap[i] > 0) gap[i]--;
        end
        if (exp_wr) begin
            b = src_q[m_owner].pop_front();
            if (rnd) gap[m_owner] = b.last ? int'($urandom_range(0, 6)) : int'($urandom_range(0, 2));
        end

        pick = 0;
        if (reset) begin
            m_busy = 1'b0; m_owner = 0; m_last = NREQ - 1; m_cnt = 0;
        end else if (!m_busy) begin
            if (|req_valid) begin
                for (int k = NREQ; k >= 1; k--) begin
                    if (req_valid[(m_last + k) % NREQ]) pick = (m_last + k) % NREQ;
                end
                m_owner = pick; m_busy = 1'b1; m_cnt = 0;
            end
        end else if (exp_wr) begin
            m_cnt = 0;
            if (req_last[m_owner]) begin
                m_last = m_owner; m_busy = 1'b0;
            end
        end else if (!req_valid[m_owner]) begin
            if (exp_abort) begin
                m_last = m_owner; m_busy = 1'b0; m_cnt = 0;
            end else m_cnt++;
        end
    endtask

    task automatic drain(input int limit);
        int n;
        n = 0;
        while ((pending() || m_busy) && n < limit) begin
            cycle();
            n++;
        end
        chk("drain_in_budget", n < limit, 1);
        cycle();
    endtask

    task automatic do_reset();
        rst_cmd = 1'b1;
        cycle();
        rst_cmd = 1'b0;
        flush();
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, nwr0, ab0, len;
        int t2_exp[4];
        t2_exp = '{1, 3, 1, 3};
        reset = 1'b1; rst_cmd = 1'b1; full_cmd = 1'b0; tx_full = 1'b0; rnd = 1'b0;
        req_valid = '0; req_data = '0; req_last = '0;
        m_busy = 1'b0; m_owner = 0; m_last = NREQ - 1; m_cnt = 0;
        n_abort = 0; abort_cyc = 0; max_wait = 0;
        prev_busy = 1'b0; prev_valid = '0;
        for (int i = 0; i < NREQ; i++) begin gap[i] = 0; waitc[i] = 0; end
        repeat (2) @(posedge clk);
        cycle();
        rst_cmd = 1'b0;

        // T1: single 3-byte packet from req0
        wr_cycs.delete();
        push_byte(0, 8'h41, 1'b0); push_byte(0, 8'h42, 1'b0); push_byte(0, 8'h43, 1'b1);
        t0 = cyc + 1;
        drain(50);
        chk("t1_nwr", wr_cycs.size(), 3);
        chk("t1_first_wr", (wr_cycs.size() > 0) ? wr_cycs[0] - t0 : -1, 1);
        chk("t1_last_wr", (wr_cycs.size() > 2) ? wr_cycs[2] - t0 : -1, 3);

        // T2: req1 and req3 contend from reset
        do_reset();
        gq.delete();
        push_byte(1, 8'h11, 1'b0); push_byte(1, 8'h12, 1'b1);
        push_byte(1, 8'h13, 1'b0); push_byte(1, 8'h14, 1'b1);
        push_byte(3, 8'h31, 1'b0); push_byte(3, 8'h32, 1'b1);
        push_byte(3, 8'h33, 1'b0); push_byte(3, 8'h34, 1'b1);
        drain(100);
        chk("t2_ngrants", gq.size(), 4);
        for (int k = 0; k < 4; k++)
            chk($sformatf("t2_grant%0d", k), (k < gq.size()) ? gq[k] : -1, t2_exp[k]);

        // T3: tx_full for 5 cycles mid-packet
        wr_cycs.delete();
        ab0 = n_abort;
        for (int k = 0; k < 6; k++) push_byte(0, 8'(8'h60 + k), k == 5);
        for (int n = 0; n < 20 && wr_cycs.size() < 2; n++) cycle();
        chk("t3_reach_mid", wr_cycs.size(), 2);
        nwr0 = wr_cycs.size();
        full_cmd = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("t3_wr_full", wr_uart, 1'b0);
            chk("t3_rdy_full", req_ready, '0);
        end
        chk("t3_no_wr_stalled", wr_cycs.size(), nwr0);
        full_cmd = 1'b0;
        drain(50);
        chk("t3_nwr", wr_cycs.size(), 6);
        chk("t3_abort", n_abort - ab0, 0);
        chk("t3_sb_left", exp_q[0].size(), 0);

        // T4: req2 stalls after one byte, req0 waiting
        wr_cycs.delete();
        gq.delete();
        ab0 = n_abort;
        push_byte(2, 8'h52, 1'b0);
        push_byte(0, 8'h01, 1'b0); push_byte(0, 8'h02, 1'b1);
        drain(80);
        chk("t4_abort_once", n_abort - ab0, 1);
        chk("t4_abort_delay", (wr_cycs.size() > 0) ? abort_cyc - wr_cycs[0] : -1, TO);
        chk("t4_first_grant", (gq.size() > 0) ? gq[0] : -1, 2);
        chk("t4_next_grant", (gq.size() > 1) ? gq[1] : -1, 0);

        // T5: reset in the middle of a req1 packet
        wr_cycs.delete();
        for (int k = 0; k < 5; k++) push_byte(1, 8'(8'h71 + k), k == 4);
        for (int n = 0; n < 20 && wr_cycs.size() < 2; n++) cycle();
        chk("t5_reach_mid", busy, 1'b1);
        do_reset();
        cycle();
        chk("t5_busy", busy, 1'b0);
        chk("t5_wr", wr_uart, 1'b0);
        chk("t5_rdy", req_ready, '0);
        gq.delete();
        push_byte(1, 8'h81, 1'b1);
        push_byte(0, 8'h91, 1'b1);
        drain(50);
        chk("t5_grant_req0", (gq.size() > 0) ? gq[0] : -1, 0);

        // T6: random traffic on all ports
        rnd = 1'b1;
        ab0 = n_abort;
        max_wait = 0;
        for (int i = 0; i < NREQ; i++) waitc[i] = 0;
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (src_q[i].size() == 0) begin
                    len = int'($urandom_range(1, 4));
                    for (int b = 0; b < len; b++) push_byte(i, 8'($urandom), b == len - 1);
                end
            end
            full_cmd = ($urandom_range(0, 3) == 0);
            cycle();
        end
        full_cmd = 1'b0;
        drain(500);
        chk("t6_no_abort", n_abort - ab0, 0);
        chk("t6_fair", max_wait < NREQ, 1);
        for (int i = 0; i < NREQ; i++)
            chk($sformatf("t6_sb_left%0d", i), exp_q[i].size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
